// File: rtl/operand_solver_pkg.sv
// Shared types and encodings for the operand solver: FSM states,
// negate-select and unknown-select codes, and the default data width.
package operand_solver_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SUB  = 2'b01,
    NEG  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Negated-operand select
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_NEG_A = 2'b01;
  localparam logic [1:0] OP_NEG_B = 2'b10;
  localparam logic [1:0] OP_NEG_C = 2'b11;

  // Unknown-operand select; also used as the operand identity A/B/C
  localparam logic [1:0] UNK_A   = 2'b00;
  localparam logic [1:0] UNK_B   = 2'b01;
  localparam logic [1:0] UNK_C   = 2'b10;
  localparam logic [1:0] UNK_BAD = 2'b11;

  // True when op negates the operand with identity id (A/B/C coded as UNK_*).
  // Each OP_NEG_* code is exactly one above the matching UNK_* code.
  function automatic logic op_negates(input logic [1:0] op, input logic [1:0] id);
    logic [1:0] idx;
    idx = op - 2'd1;
    return (op != OP_NONE) && (idx == id);
  endfunction

endpackage

// File: rtl/operand_solver_if.sv
// Request/response bundle of the operand solver. The master issues requests
// and consumes results; the slave is the solver itself.
interface operand_solver_if #(
  parameter int WIDTH = operand_solver_pkg::WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] k1;
  logic [WIDTH-1:0] k2;
  logic [1:0]       op;
  logic [1:0]       unk;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x;
  logic             err;

  modport master (
    output in_valid, r, k1, k2, op, unk, out_ready,
    input  in_ready, out_valid, x, err
  );

  modport slave (
    input  in_valid, r, k1, k2, op, unk, out_ready,
    output in_ready, out_valid, x, err
  );
endinterface

// File: rtl/operand_solver_serial_sub_cell.sv
// One bit slice of r - a - b. The borrow can reach 2 because two subtrahend
// bits plus the incoming borrow are removed from a single minuend bit.
module serial_sub_cell (
  input  logic       r_bit,
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic [1:0] borrow_in,
  output logic       diff_bit,
  output logic [1:0] borrow_out
);

  logic [2:0] sum_s;

  // Total amount subtracted at this bit position, then the digit and borrow.
  // An odd remainder with r_bit=0 needs one extra borrow to make the digit 1.
  always_comb begin
    sum_s      = {2'b00, a_bit} + {2'b00, b_bit} + {1'b0, borrow_in};
    diff_bit   = r_bit ^ sum_s[0];
    borrow_out = sum_s[2:1] + {1'b0, sum_s[0] & ~r_bit};
  end

endmodule

// File: rtl/operand_solver.sv
// Recovers the unknown operand of a three-operand add/negate adder.
// Known operands are negated at accept, then T = r - k1' - k2' is formed
// bit-serially; if the unknown itself was negated, x = -T is formed serially.
module operand_solver
  import operand_solver_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  operand_solver_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       borrow_q, borrow_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             neg_unk_q, neg_unk_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             err_q, err_d;

  logic             cell_diff_s;
  logic [1:0]       cell_borrow_s;
  logic             neg_bit_s;
  logic [1:0]       k1_id_s;
  logic [1:0]       k2_id_s;

  serial_sub_cell u_sub_cell (
    .r_bit      (r_q[0]),
    .a_bit      (a_q[0]),
    .b_bit      (b_q[0]),
    .borrow_in  (borrow_q),
    .diff_bit   (cell_diff_s),
    .borrow_out (cell_borrow_s)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.x         = x_q;
  assign bus.err       = err_q;

  // Next-state and datapath: accept, serial subtract, serial negate, hold result.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    carry_d   = carry_q;
    r_d       = r_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    neg_unk_d = neg_unk_q;
    x_d       = x_q;
    err_d     = err_q;

    // Identity of k1/k2: A,B,C order with the unknown removed
    k1_id_s   = (bus.unk == UNK_A) ? UNK_B : UNK_A;
    k2_id_s   = (bus.unk == UNK_C) ? UNK_B : UNK_C;

    // Serial two's complement: invert and add the carry seeded with 1
    neg_bit_s = ~res_q[0] ^ carry_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.unk == UNK_BAD) begin
            state_d = DONE;
            x_d     = {WIDTH{1'b0}};
            err_d   = 1'b1;
          end else begin
            state_d   = SUB;
            r_d       = bus.r;
            a_d       = op_negates(bus.op, k1_id_s) ? (~bus.k1 + ONE) : bus.k1;
            b_d       = op_negates(bus.op, k2_id_s) ? (~bus.k2 + ONE) : bus.k2;
            neg_unk_d = op_negates(bus.op, bus.unk);
            cnt_d     = {CNT_W{1'b0}};
            borrow_d  = 2'b00;
            err_d     = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      SUB: begin
        r_d      = {1'b0, r_q[WIDTH-1:1]};
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        res_d    = {cell_diff_s, res_q[WIDTH-1:1]};
        borrow_d = cell_borrow_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          carry_d = 1'b1;
          if (neg_unk_q) begin
            state_d = NEG;
          end else begin
            state_d = DONE;
            x_d     = {cell_diff_s, res_q[WIDTH-1:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      NEG: begin
        res_d   = {neg_bit_s, res_q[WIDTH-1:1]};
        carry_d = ~res_q[0] & carry_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = DONE;
          x_d     = {neg_bit_s, res_q[WIDTH-1:1]};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      borrow_q  <= 2'b00;
      carry_q   <= 1'b0;
      r_q       <= {WIDTH{1'b0}};
      a_q       <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      res_q     <= {WIDTH{1'b0}};
      neg_unk_q <= 1'b0;
      x_q       <= {WIDTH{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      borrow_q  <= borrow_d;
      carry_q   <= carry_d;
      r_q       <= r_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      neg_unk_q <= neg_unk_d;
      x_q       <= x_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_operand_solver.sv
// Directed-vector bench for operand_solver with hand-computed results.
module tb_operand_solver;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   lat;

  operand_solver_if #(.WIDTH(8)) bus_if ();

  operand_solver #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and let it be accepted; scramble inputs afterwards.
  task automatic start(input logic [1:0] op, input logic [1:0] unk,
                       input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] r);
    @(negedge clk);
    bus_if.op       = op;
    bus_if.unk      = unk;
    bus_if.k1       = k1;
    bus_if.k2       = k2;
    bus_if.r        = r;
    bus_if.in_valid = 1'b1;
    check_eq("in_ready_before_accept", {31'd0, bus_if.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    bus_if.op       = 2'b10;
    bus_if.unk      = 2'b01;
    bus_if.k1       = 8'hA5;
    bus_if.k2       = 8'h5A;
    bus_if.r        = 8'hC3;
  endtask

  // Count clock edges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus_if.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Complete the output handshake and confirm the return to idle.
  task automatic finish_out();
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    check_eq("out_valid_after_hs", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("in_ready_after_hs", {31'd0, bus_if.in_ready}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [1:0] op, input logic [1:0] unk,
                         input logic [7:0] k1, input logic [7:0] k2, input logic [7:0] r,
                         input logic [7:0] exp_x, input logic exp_err, input int exp_lat);
    int n;
    start(op, unk, k1, k2, r);
    if (exp_lat > 0) begin
      check_eq({tag, "_busy"}, {31'd0, bus_if.in_ready}, 32'd0);
    end else begin
      check_eq({tag, "_busy_bad"}, {31'd0, bus_if.in_ready}, 32'd0);
    end
    wait_done(n);
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_x"}, {24'd0, bus_if.x}, {24'd0, exp_x});
    check_eq({tag, "_err"}, {31'd0, bus_if.err}, {31'd0, exp_err});
    finish_out();
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.op        = 2'b00;
    bus_if.unk       = 2'b00;
    bus_if.k1        = 8'h00;
    bus_if.k2        = 8'h00;
    bus_if.r         = 8'h00;

    #12;
    check_eq("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("rst_x", {24'd0, bus_if.x}, 32'd0);
    check_eq("rst_err", {31'd0, bus_if.err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, negate-unknown, wrap-around and illegal requests
    run_vec("plain_a",   2'b00, 2'b00, 8'h10, 8'h20, 8'h35, 8'h05, 1'b0, 8);
    run_vec("neg_a",     2'b01, 2'b00, 8'h10, 8'h20, 8'h2B, 8'h05, 1'b0, 16);
    run_vec("wrap_c",    2'b00, 2'b10, 8'hFF, 8'h02, 8'h00, 8'hFF, 1'b0, 8);
    run_vec("illegal",   2'b01, 2'b11, 8'hAA, 8'h55, 8'h77, 8'h00, 1'b1, 0);
    // B negated and unknown: 0x11 - 0x07 + 0x22 = 0x2C
    run_vec("neg_b",     2'b10, 2'b01, 8'h11, 8'h22, 8'h2C, 8'h07, 1'b0, 16);
    // Known C negated: 0x40 + 0x01 - 0x03 = 0x3E
    run_vec("known_neg", 2'b11, 2'b00, 8'h01, 8'h03, 8'h3E, 8'h40, 1'b0, 8);
    // Maximal known operands, r=0: A = -0x1FE = 0x02
    run_vec("max_ops",   2'b00, 2'b00, 8'hFF, 8'hFF, 8'h00, 8'h02, 1'b0, 8);
    // C negated and unknown: 0xFF + 0xFF - 0xFE = 0x100 -> 0x00
    run_vec("max_neg_c", 2'b11, 2'b10, 8'hFF, 8'hFF, 8'h00, 8'hFE, 1'b0, 16);

    // Back-pressure: result held 5 clocks, no accept on the handshake edge
    start(2'b00, 2'b00, 8'h10, 8'h20, 8'h35);
    wait_done(lat);
    check_eq("bp_lat", lat, 8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
      check_eq("bp_x", {24'd0, bus_if.x}, 32'h05);
      check_eq("bp_err", {31'd0, bus_if.err}, 32'd0);
      check_eq("bp_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    end
    @(negedge clk);
    // Next request: unknown B, A=0x01, C=0x02, B=0x03 -> r=0x06
    bus_if.op        = 2'b00;
    bus_if.unk       = 2'b01;
    bus_if.k1        = 8'h01;
    bus_if.k2        = 8'h02;
    bus_if.r         = 8'h06;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
    check_eq("hs_no_accept_ov", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("hs_no_accept_ir", {31'd0, bus_if.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    check_eq("hs_next_accept", {31'd0, bus_if.in_ready}, 32'd0);
    wait_done(lat);
    check_eq("hs_next_lat", lat, 8);
    check_eq("hs_next_x", {24'd0, bus_if.x}, 32'h03);
    finish_out();

    // Reset mid-SUB aborts; the next request behaves as from power-up
    start(2'b01, 2'b00, 8'h10, 8'h20, 8'h2B);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("abort_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    check_eq("abort_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("abort_no_result", {31'd0, bus_if.out_valid}, 32'd0);
    run_vec("after_rst", 2'b00, 2'b00, 8'h10, 8'h20, 8'h35, 8'h05, 1'b0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
